// File: rtl/vga_pkg.sv
// Shared VGA display constants, RGB444 pixel type and colour-bar palette.
// Latency: n/a (package only).
// Backpressure: n/a.
package vga_pkg;

    localparam int H_DISP = 640;
    localparam int V_DISP = 480;
    localparam int SRC_W  = 320;
    localparam int SRC_H  = 240;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Bars run left to right in this order.
    localparam rgb444_t BAR_COLOURS [0:7] = '{
        12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
        12'hF0F, 12'hF00, 12'h00F, 12'h000
    };

    // Which of the 8 equal-width bars a display column falls in.
    function automatic logic [2:0] bar_index(input logic [9:0] x, input int bar_w);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (int'(x) >= i * bar_w) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Generic DEPTH x WIDTH shift register with a parameterised reset value; all taps exposed.
// Latency: DEPTH cycles from din to dout.
// Backpressure: none; shifts every cycle.
module vga_sync_delay #(
    parameter int               DEPTH   = 3,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [DEPTH-1:0][WIDTH-1:0]  taps
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    // Shift one stage per cycle; every stage resets to the idle value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {DEPTH{RST_VAL}};
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];
    assign taps = sr;

endmodule

// File: rtl/vga_frame_reader.sv
// Fetches 320x240 RGB565 frame-buffer pixels with 2x upscale, converts to RGB444, aligns syncs.
// Latency: RD_LAT + 2 cycles from counters/syncs to RGB, sync and video outputs.
// Backpressure: none; free-running pixel stream, one BRAM read per active pixel.
module vga_frame_reader #(
    parameter int H_DISP = vga_pkg::H_DISP,
    parameter int V_DISP = vga_pkg::V_DISP,
    parameter int SRC_W  = vga_pkg::SRC_W,
    parameter int RD_LAT = 1,
    parameter int ADDR_W = 17
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [9:0]        i_x_counter,
    input  logic [9:0]        i_y_counter,
    input  logic              i_video,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_pattern_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [15:0]       i_rd_data,
    output logic [3:0]        o_red,
    output logic [3:0]        o_green,
    output logic [3:0]        o_blue,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_video
);
    import vga_pkg::*;

    localparam int          DEPTH    = RD_LAT + 2;
    localparam int          DW       = 13;
    localparam int          BAR_W    = H_DISP / 8;
    localparam logic [9:0]  H_DISP_C = 10'(H_DISP);
    localparam logic [9:0]  V_DISP_C = 10'(V_DISP);
    localparam logic [ADDR_W-1:0] SRC_W_C = ADDR_W'(SRC_W);
    // Idle delay-line value: syncs deasserted (high), video off, x = 0.
    localparam logic [DW-1:0] DLY_RST = {1'b1, 1'b1, 1'b0, 10'd0};

    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_en_q;
    logic              pattern_q;
    logic              frame_start;
    logic              rd_go;
    logic              line_done;

    logic [DW-1:0]             dly_out;
    logic [DEPTH-1:0][DW-1:0]  dly_taps;
    logic [DW-1:0]             tap_c;
    logic [9:0]                x_c;
    logic                      video_c;
    rgb444_t                   pix;
    rgb444_t                   rgb_q;

    assign frame_start = (i_x_counter == 10'd0) && (i_y_counter == V_DISP_C);
    // Out-of-range counters never issue reads, keeping the address inside the buffer.
    assign rd_go       = i_video && (i_x_counter < H_DISP_C) && (i_y_counter < V_DISP_C);
    // Each source row is shown on two display lines: advance after the odd one.
    assign line_done   = (i_x_counter == H_DISP_C) && (i_y_counter < V_DISP_C) && i_y_counter[0];

    // Source-row base address, restarted at the top of every frame.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            line_base <= '0;
        end else if (frame_start) begin
            line_base <= '0;
        end else if (line_done) begin
            line_base <= line_base + SRC_W_C;
        end
    end

    // Pattern select only changes in vertical blanking so a frame never tears.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            pattern_q <= 1'b0;
        end else if (frame_start) begin
            pattern_q <= i_pattern_en;
        end
    end

    // Read request: horizontal halving gives the 2x upscale; address holds when idle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
        end else begin
            rd_en_q <= rd_go;
            if (rd_go) begin
                rd_addr_q <= line_base + ADDR_W'(i_x_counter[9:1]);
            end
        end
    end

    assign o_rd_en   = rd_en_q;
    assign o_rd_addr = rd_addr_q;

    vga_sync_delay #(
        .DEPTH   (DEPTH),
        .WIDTH   (DW),
        .RST_VAL (DLY_RST)
    ) u_dly (
        .clk   (i_clk),
        .rst_n (i_rstn),
        .din   ({i_hsync, i_vsync, i_video, i_x_counter}),
        .dout  (dly_out),
        .taps  (dly_taps)
    );

    // Tap RD_LAT lines up with the BRAM data arriving at the conversion register.
    assign tap_c   = dly_taps[RD_LAT];
    assign x_c     = tap_c[9:0];
    assign video_c = tap_c[10];

    // Colour selection: blank outside active video, bars or truncated RGB565.
    always_comb begin
        pix = '0;
        if (video_c) begin
            if (pattern_q) begin
                pix = BAR_COLOURS[bar_index(x_c, BAR_W)];
            end else begin
                pix.r = i_rd_data[15:12];
                pix.g = i_rd_data[10:7];
                pix.b = i_rd_data[4:1];
            end
        end
    end

    // Conversion register, same clock edge as the last delay-line stage.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= pix;
        end
    end

    assign o_red   = rgb_q.r;
    assign o_green = rgb_q.g;
    assign o_blue  = rgb_q.b;
    assign o_hsync = dly_out[12];
    assign o_vsync = dly_out[11];
    assign o_video = dly_out[10];

    // Dropped low-order colour bits and taps not needed at the outputs.
    logic unused_bits;
    assign unused_bits = ^{i_rd_data[11], i_rd_data[6:5], i_rd_data[0], dly_out[9:0], dly_taps};

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Pixel-fetch stage between the VGA timing generator and the DAC pins. It takes the generator's x/y counters, video-active flag and active-low syncs, and fetches 320x240 RGB565 camera pixels from the frame-buffer BRAM read port with 2x upscaling to 640x480. It converts each pixel to RGB444 and delays the syncs so colour and sync leave the block on the same cycle. A colour-bar test pattern can replace camera data for bring-up.

## Interface
- H_DISP, 640, active pixels per line (must match timing generator)
- V_DISP, 480, active lines per frame
- SRC_W, 320, frame-buffer width (= H_DISP/2)
- SRC_H, 240, frame-buffer height (= V_DISP/2)
- RD_LAT, 1, BRAM read latency in cycles, legal 1..3
- ADDR_W, 17, frame-buffer address width (ceil(log2(SRC_W*SRC_H)))

Ports:
- i_clk  in  1  pixel clock, same clock as the timing generator
- i_rstn  in  1  asynchronous active-low reset
- i_x_counter  in  10  horizontal count from the timing generator
- i_y_counter  in  10  vertical count from the timing generator
- i_video  in  1  active-display flag
- i_hsync  in  1  active-low hsync
- i_vsync  in  1  active-low vsync
- i_pattern_en  in  1  request colour bars instead of camera data
- o_rd_en  out  1  BRAM read enable
- o_rd_addr  out  ADDR_W  BRAM read address, row-major: y_src*SRC_W + x_src
- i_rd_data  in  16  RGB565 from BRAM, valid RD_LAT cycles after o_rd_en
- o_red, o_green, o_blue  out  4 each  RGB444 to DAC
- o_hsync, o_vsync  out  1  delayed active-low syncs
- o_video  out  1  delayed active-display flag

## Operation
- Stage A (register): o_rd_en = i_video; o_rd_addr = line_base + (i_x_counter >> 1) when i_video is high, otherwise o_rd_addr holds its last value.
- line_base register: add SRC_W when i_x_counter == H_DISP and i_y_counter < V_DISP and i_y_counter[0] == 1. This advances once per pair of display lines.
- Frame boundary: i_x_counter == 0 and i_y_counter == V_DISP.
  - At the boundary, line_base is cleared to 0.
  - At the boundary, i_pattern_en is sampled into pattern_q.
- Stage B (RD_LAT cycles): BRAM access. The block holds no state for this stage except the delay lines.
- Stage C (register): conversion.
  - Camera mode: red = d[15:12], green = d[10:7], blue = d[4:1].
  - If pattern_q is set: 8 bars, each 80 px wide, selected by x delayed to stage C. Colours in order: white FFF, yellow FF0, cyan 0FF, green 0F0, magenta F0F, red F00, blue 00F, black 000.
  - If delayed video is 0, RGB is forced to 000.
- Sync/video/x delay: the shift registers are 1+RD_LAT+1 deep.
- Address arithmetic is unsigned, ADDR_W wide. It never exceeds SRC_W*SRC_H-1 when the inputs are within range. Counter values at or above H_DISP/V_DISP do not generate reads.
- Reset mid-frame: line_base is cleared immediately. Addresses are wrong until the next frame boundary if the timing generator was not reset together with this block. Syncs are unaffected beyond the pipeline flush.

## Timing
- Total latency L = RD_LAT + 2 cycles from inputs to o_red/o_green/o_blue/o_hsync/o_vsync/o_video. With default parameters L = 3.
- hsync, vsync, video and RGB shift by the same L. Their relative alignment equals the input alignment exactly.
- A change of i_pattern_en takes effect only at the next frame boundary, so no tearing occurs.
- Reset values:
  - o_rd_en 0, o_rd_addr 0.
  - RGB 000, o_video 0.
  - o_hsync 1, o_vsync 1.
  - All delay-line taps: sync 1, video 0.
  - line_base 0, pattern_q 0.

## Structure
- Package vga_pkg holds:
  - H_DISP, V_DISP, SRC_W, SRC_H defaults, shared with the timing generator.
  - typedef rgb444_t (packed struct r/g/b, 4 bits each).
  - localparam array of the 8 colour-bar rgb444_t values.
- Sub-module vga_sync_delay: a generic DEPTH x WIDTH shift register with an asynchronous reset value parameter. It is instantiated for {hsync, vsync, video, x[9:0]}.

## Test plan
- Reset asserted mid-line -> within the same cycle: o_hsync = o_vsync = 1, RGB 000, o_rd_en 0, o_rd_addr 0.
- Sweep of y = 0, x = 0..3 -> o_rd_addr 0, 0, 1, 1 one cycle later. y = 1, x = 0 -> addr 0. y = 2, x = 0 -> addr 320. y = 479, x = 639 -> addr 76799.
- BRAM model (RD_LAT = 1) returns F800 at the address for x = 10 -> o_red = F, o_green = 0, o_blue = 0 exactly 3 cycles after x = 10 is presented. An i_hsync falling edge at x = 656 appears on o_hsync 3 cycles later.
- i_video = 0 with i_rd_data = FFFF -> RGB 000 while o_video = 0. o_rd_en stays 0 and o_rd_addr holds.
- i_pattern_en raised at y = 100 -> the current frame still shows camera data. In the next frame, x = 0..79 gives FFF, x = 80 gives FF0, and x = 560..639 gives 000.
- Run 2 full frames of 800x525 -> line_base returns to 0 at y = 480. The same pixel addresses repeat in frame 2, and the number of o_rd_en pulses equals 307200 per frame.
